// File: rtl/gb_lcd_pkg.sv
// Shared constants and types for the GameBoy LCD capture path.
package gb_lcd_pkg;

    localparam int H_PIXELS     = 160;
    localparam int V_LINES      = 144;
    localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam int FRAME_BYTES  = FRAME_PIXELS / 4;

    typedef struct packed {
        logic        buf_id;
        logic [12:0] addr;
        logic [7:0]  data;
        logic        last;
    } cap_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } writer_state_t;

endpackage

// File: rtl/lcd_cap_fifo.sv
// Synchronous FIFO of packed capture entries; head is visible on dout while not empty.
module lcd_cap_fifo
    import gb_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cap_entry_t din,
    input  logic       pop,
    output cap_entry_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    cap_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gb_lcd_capture.sv
// Packs LCD pixels four per byte, queues them, and writes a double-buffered frame RAM,
// swapping the front buffer whenever the final byte of a frame has been written.
module gb_lcd_capture
    import gb_lcd_pkg::*;
#(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] lcd_addr,
    input  logic [1:0]  lcd_pixel,
    input  logic        lcd_valid,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        front_buf,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int          FRAME_PIX = H_PIXELS * V_LINES;
    localparam logic [14:0] LAST_ADDR = 15'(FRAME_PIX - 1);

    logic          back_buf;
    logic [7:0]    pack_reg;
    logic [7:0]    packed_byte;
    logic [1:0]    lane;
    logic          in_range;
    logic          form;
    logic          is_last;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          cur_last;
    cap_entry_t    entry_in;
    cap_entry_t    head;
    writer_state_t state;

    assign lane     = lcd_addr[1:0];
    assign in_range = lcd_valid && (lcd_addr <= LAST_ADDR);
    assign form     = in_range && (lane == 2'd3);
    assign is_last  = (lcd_addr == LAST_ADDR);

    // Merge the incoming pixel into its lane so the completing pixel is part of the byte.
    always_comb begin
        packed_byte = pack_reg;
        packed_byte[2*lane +: 2] = lcd_pixel;
    end

    always_comb begin
        entry_in.buf_id = back_buf;
        entry_in.addr   = lcd_addr[14:2];
        entry_in.data   = packed_byte;
        entry_in.last   = is_last;
    end

    assign pop  = !fifo_empty && ((state == IDLE) || fb_ready);
    assign push = form && (!fifo_full || pop);

    lcd_cap_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (entry_in),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_reg <= '0;
            back_buf <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (in_range) begin
                pack_reg <= packed_byte;
            end
            // The buffer flips even when the last byte is dropped, so that frame never swaps in.
            if (form && is_last) begin
                back_buf <= ~back_buf;
            end
            if (form && !push) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            cur_last    <= 1'b0;
            front_buf   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if ((state == WRITE) && fb_ready && cur_last) begin
                frame_done  <= 1'b1;
                front_buf   <= fb_addr[13];
                frame_count <= frame_count + 16'd1;
            end
            if (pop) begin
                fb_addr  <= {head.buf_id, head.addr};
                fb_data  <= head.data;
                cur_last <= head.last;
                fb_we    <= 1'b1;
                state    <= WRITE;
            end else if ((state == WRITE) && fb_ready) begin
                fb_we <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: vector table for short sequences, hand-written frame/overflow/reset runs.
module tb_gb_lcd_capture;

    localparam int FRAME_PIX = 160 * 144;
    localparam int FRAME_BYTE = FRAME_PIX / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] lcd_addr = '0;
    logic [1:0]  lcd_pixel = '0;
    logic        lcd_valid = 1'b0;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic        front_buf;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    always #5 clk = ~clk;

    gb_lcd_capture #(
        .H_PIXELS  (160),
        .V_LINES   (144),
        .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_addr    (lcd_addr),
        .lcd_pixel   (lcd_pixel),
        .lcd_valid   (lcd_valid),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .front_buf   (front_buf),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    int checks = 0;
    int passed = 0;
    logic toggle = 1'b0;

    logic [21:0] acc_q[$];
    int          done_pulses = 0;
    int          hold_errs = 0;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    // Accepted writes, frame_done cycles and stall stability, all sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_we && fb_ready) acc_q.push_back({fb_addr, fb_data});
        if (frame_done) done_pulses++;
        if (prev_stall && !(fb_we && fb_addr == prev_addr && fb_data == prev_data)) hold_errs++;
        prev_stall = fb_we && !fb_ready;
        prev_addr  = fb_addr;
        prev_data  = fb_data;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle) fb_ready = ~fb_ready;
    endtask

    task automatic pix(input int a, input int s);
        lcd_valid = 1'b1;
        lcd_addr  = 15'(a);
        lcd_pixel = 2'(s);
        step();
        lcd_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < FRAME_PIX; i++) begin
            lcd_valid = 1'b1;
            lcd_addr  = 15'(i);
            lcd_pixel = 2'd2;
            step();
        end
        lcd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int c = 0;
        while (acc_q.size() < n && c < budget) begin
            step();
            c++;
        end
        repeat (6) step();
        chk(name, acc_q.size(), n);
    endtask

    task automatic check_frame(input logic bufbit, input string name);
        int bad = 0;
        foreach (acc_q[i]) if (acc_q[i] !== {bufbit, 13'(i), 8'hAA}) bad++;
        chk(name, bad, 0);
    endtask

    function automatic logic [7:0] exp_byte(input int j);
        return {2'(j + 3), 2'(j + 2), 2'(j + 1), 2'(j)};
    endfunction

    typedef struct {
        logic        v;
        logic [14:0] a;
        logic [1:0]  p;
        logic        rdy;
        logic        we;
        logic [13:0] fa;
        logic [7:0]  fd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int bad;
        vecs[0]  = '{1'b1, 15'd0,     2'd1, 1'b1, 1'b0, 14'h0000, 8'h00};
        vecs[1]  = '{1'b1, 15'd1,     2'd2, 1'b1, 1'b0, 14'h0000, 8'h00};
        vecs[2]  = '{1'b1, 15'd2,     2'd3, 1'b1, 1'b0, 14'h0000, 8'h00};
        vecs[3]  = '{1'b1, 15'd3,     2'd0, 1'b1, 1'b0, 14'h0000, 8'h00};
        vecs[4]  = '{1'b0, 15'd0,     2'd0, 1'b1, 1'b1, 14'h2000, 8'h39};
        vecs[5]  = '{1'b0, 15'd0,     2'd0, 1'b1, 1'b0, 14'h0000, 8'h00};
        vecs[6]  = '{1'b1, 15'd4,     2'd3, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[7]  = '{1'b1, 15'd5,     2'd3, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[8]  = '{1'b1, 15'd6,     2'd3, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[9]  = '{1'b1, 15'd23040, 2'd0, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[10] = '{1'b1, 15'd32767, 2'd0, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[11] = '{1'b0, 15'd0,     2'd0, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[12] = '{1'b1, 15'd7,     2'd1, 1'b0, 1'b0, 14'h0000, 8'h00};
        vecs[13] = '{1'b0, 15'd0,     2'd0, 1'b0, 1'b1, 14'h2001, 8'h7F};
        vecs[14] = '{1'b0, 15'd0,     2'd0, 1'b0, 1'b1, 14'h2001, 8'h7F};
        vecs[15] = '{1'b0, 15'd0,     2'd0, 1'b1, 1'b0, 14'h0000, 8'h00};

        repeat (3) step();
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_front_buf", front_buf, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        step();

        // Out-of-range pixels at 23040 and 32767 would corrupt lane 0 or push a byte if not ignored.
        for (int i = 0; i < 16; i++) begin
            lcd_valid = vecs[i].v;
            lcd_addr  = vecs[i].a;
            lcd_pixel = vecs[i].p;
            fb_ready  = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_we", i), fb_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr", i), fb_addr, vecs[i].fa);
                chk($sformatf("vec%0d_data", i), fb_data, vecs[i].fd);
            end
        end
        lcd_valid = 1'b0;
        fb_ready  = 1'b1;
        repeat (4) step();
        chk("vec_frame_count", frame_count, 0);

        acc_q.delete();
        done_pulses = 0;
        send_frame();
        wait_writes(FRAME_BYTE, 50, "frame1_writes");
        check_frame(1'b1, "frame1_content");
        chk("frame1_done_pulses", done_pulses, 1);
        chk("frame1_front_buf", front_buf, 1);
        chk("frame1_count", frame_count, 1);

        acc_q.delete();
        done_pulses = 0;
        send_frame();
        wait_writes(FRAME_BYTE, 50, "frame2_writes");
        check_frame(1'b0, "frame2_content");
        chk("frame2_done_pulses", done_pulses, 1);
        chk("frame2_front_buf", front_buf, 0);
        chk("frame2_count", frame_count, 2);

        // With the RAM stalled, one byte waits in the output register and eight fill the FIFO.
        acc_q.delete();
        hold_errs = 0;
        fb_ready  = 1'b0;
        for (int j = 0; j < 10; j++)
            for (int l = 0; l < 4; l++) pix(j * 4 + l, j + l);
        step();
        chk("ovf_set", overflow, 1);
        chk("ovf_stall_we", fb_we, 1);
        chk("ovf_stall_addr", fb_addr, 14'h2000);
        chk("ovf_no_writes", acc_q.size(), 0);
        fb_ready = 1'b1;
        wait_writes(9, 40, "ovf_writes");
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] !== {1'b1, 13'(i), exp_byte(i)}) bad++;
        chk("ovf_order", bad, 0);
        chk("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);

        acc_q.delete();
        toggle   = 1'b1;
        fb_ready = 1'b0;
        for (int j = 0; j < 8; j++)
            for (int l = 0; l < 4; l++) pix((20 + j) * 4 + l, j + l);
        wait_writes(8, 40, "tog_writes");
        toggle   = 1'b0;
        fb_ready = 1'b1;
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] !== {1'b1, 13'(20 + i), exp_byte(i)}) bad++;
        chk("tog_order", bad, 0);
        chk("tog_hold_stable", hold_errs, 0);
        chk("tog_no_overflow", overflow, 0);

        fb_ready = 1'b0;
        for (int i = 0; i < 100; i++) pix(i, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_fb_we", fb_we, 0);
        chk("mid_rst_fb_addr", fb_addr, 0);
        chk("mid_rst_fb_data", fb_data, 0);
        chk("mid_rst_front_buf", front_buf, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_overflow", overflow, 0);
        acc_q.delete();
        done_pulses = 0;
        fb_ready = 1'b1;
        repeat (20) step();
        chk("mid_rst_no_writes", acc_q.size(), 0);
        send_frame();
        wait_writes(FRAME_BYTE, 50, "rst_frame_writes");
        check_frame(1'b1, "rst_frame_content");
        chk("rst_frame_done_pulses", done_pulses, 1);
        chk("rst_frame_front_buf", front_buf, 1);
        chk("rst_frame_count", frame_count, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
